div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 127 ++++++++++++
 tb/tb_div.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Iterative 32-bit divider for the EX stage: restoring shift-subtract, one bit per cycle,
// with signed/unsigned modes, divide-by-zero shortcut and pipeline cancel.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    input  logic        start,
    input  logic        cancel,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] result_q, result_d;

    logic [64:0] shifted;
    logic [64:0] step;
    logic [32:0] diff;
    logic [31:0] mag1, mag2;
    logic [31:0] quot, rem;
    logic [31:0] quot_fix, rem_fix;

    always_comb begin
        shifted = {work_q[63:0], 1'b0};
        diff    = shifted[64:32] - {1'b0, dvsr_q};
        // Upper 33 bits hold the partial remainder; quotient bits shift in from the bottom.
        if (shifted[64:32] >= {1'b0, dvsr_q}) begin
            step = {diff, shifted[31:1], 1'b1};
        end else begin
            step = shifted;
        end

        mag1     = (signed_div && op_1[31]) ? (32'd0 - op_1) : op_1;
        mag2     = (signed_div && op_2[31]) ? (32'd0 - op_2) : op_2;
        quot     = work_q[31:0];
        rem      = work_q[63:32];
        quot_fix = negq_q ? (32'd0 - quot) : quot;
        rem_fix  = negr_q ? (32'd0 - rem) : rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (op_2 != 32'd0) begin
                        state_d = ON;
                        cnt_d   = '0;
                        work_d  = {33'd0, mag1};
                        dvsr_d  = mag2;
                        negq_d  = signed_div & (op_1[31] ^ op_2[31]);
                        negr_d  = signed_div & op_1[31];
                    end else begin
                        state_d = BY_ZERO;
                    end
                end
            end
            BY_ZERO: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    result_d = '0;
                end
            end
            ON: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'd32) begin
                    state_d  = END;
                    result_d = {rem_fix, quot_fix};
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            END: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = (state_q == END);
    assign busy   = (state_q == ON) || (state_q == BY_ZERO);

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes expected {remainder, quotient} and busy length,
// a negedge monitor pops on each ready rise; directed corner cases plus random operands.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op_1, op_2;
    logic        start, cancel;
    logic [63:0] result;
    logic        ready, busy;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] last_res;
    bit          done  = 1'b0;

    div dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .op_1       (op_1),
        .op_2       (op_2),
        .start      (start),
        .cancel     (cancel),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles and checks each completed division against the scoreboard.
    initial begin : monitor
        int   busy_cnt = 0;
        logic ready_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            if (ready) begin
                if (!ready_prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_ready", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", result, e.res);
                        check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                        last_res = e.res;
                    end
                end else begin
                    check("result_hold_end", result, last_res);
                end
                busy_cnt = 0;
            end else if (!busy) begin
                busy_cnt = 0;
            end
            ready_prev = ready;
        end
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   seen = 1'b0;
        e.res = ref_div(s, a, b);
        e.lat = (b == 32'd0) ? 1 : 33;
        sb_q.push_back(e);
        @(posedge clk); #1;
        signed_div = s; op_1 = a; op_2 = b; start = 1'b1;
        @(posedge clk); #1;
        // operands wander while the divider works; the latched copies must be used
        op_1 = $urandom; op_2 = $urandom; signed_div = $urandom_range(0, 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_and_wait(input int iters);
        @(posedge clk); #1;
        signed_div = 1'b0; op_1 = 32'd1000; op_2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (iters) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
        op_1 = '0; op_2 = '0; last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);

        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, 32'hFFFFFFF9, 32'd2);
        issue(1'b0, 32'd55, 32'd0);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        issue(1'b0, 32'hFFFFFFFF, 32'd1);
        issue(1'b0, 32'd3, 32'hFFFFFFFF);
        issue(1'b1, 32'd7, 32'hFFFFFFFE);
        issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE);

        // Cancel mid-division: result must keep the previous value, ready must stay low.
        start_and_wait(10);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_ready", 64'(ready), 64'd0);
        check("cancel_result", result, last_res);
        repeat (40) @(negedge clk);
        check("cancel_no_ready", 64'(ready), 64'd0);
        issue(1'b0, 32'd100, 32'd7);

        // Reset mid-division.
        start_and_wait(20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        last_res = 64'd0;
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            issue(1'($urandom_range(0, 1)), a, b);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
